// File: rtl/serial_adder_8bit.sv
// Bit-serial ripple adder: one full-adder slice reused over WIDTH cycles,
// LSB first, with the inter-bit carry held in a flip-flop.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for Start; operands loaded on the accepting edge
// RUN   | one sum bit per edge, WIDTH edges, result latched on last
// DONE  | single-cycle Done pulse, Start ignored, then back to IDLE
module serial_adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;

  logic             w_s;
  logic             w_c_nxt;
  logic             w_last;

  // Full-adder slice on the current LSBs plus the held carry.
  assign w_s     = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
  assign w_c_nxt = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);
  assign w_last  = (r_cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; Start is only looked at from IDLE so requests while busy drop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (Start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting and result latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_a_sh <= A;
            r_b_sh <= B;
            r_c    <= Cin;
            r_cnt  <= '0;
          end
        end
        RUN: begin
          r_s_sh <= {w_s, r_s_sh[WIDTH-1:1]};
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_c    <= w_c_nxt;
          if (w_last) begin
            // Counter parks at zero so it never leaves 0..WIDTH-1.
            r_cnt   <= '0;
            r_sum   <= {w_s, r_s_sh[WIDTH-1:1]};
            r_carry <= w_c_nxt;
            // r_c here is the carry into the MSB slice.
            r_ovf   <= r_c ^ w_c_nxt;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy  = (r_state != IDLE);
  assign Done  = (r_state == DONE);
  assign Sum   = r_sum;
  assign Carry = r_carry;
  assign Ovf   = r_ovf;

endmodule

// File: tb/tb_serial_adder_8bit.sv
// Directed bench for serial_adder_8bit: latency, flags, async reset,
// handshake drop and a Start-held sweep against A+B+Cin.
module tb_serial_adder_8bit;

  logic       clk;
  logic       rst_n;
  logic       Start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic       Busy;
  logic       Done;
  logic [7:0] Sum;
  logic       Carry;
  logic       Ovf;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  serial_adder_8bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Carry (Carry),
    .Ovf   (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pulsed operation; checks latency, busy length, single Done and results.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] e_sum, input logic e_c,
                        input logic e_o);
    int done_at;
    int busy_n;
    int done_n;
    logic [7:0] s_sum;
    logic s_c;
    logic s_o;
    done_at = 0;
    busy_n  = 0;
    done_n  = 0;
    s_sum   = 8'hxx;
    s_c     = 1'bx;
    s_o     = 1'bx;
    @(negedge clk);
    A = a; B = b; Cin = ci; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    if (Busy) busy_n++;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        if (done_at == 0) begin
          done_at = i;
          s_sum = Sum; s_c = Carry; s_o = Ovf;
        end
      end
    end
    chk({tag, "_done_lat"}, done_at, 8);
    chk({tag, "_done_cnt"}, done_n, 1);
    chk({tag, "_busy_len"}, busy_n, 9);
    chk({tag, "_sum"}, {24'd0, s_sum}, {24'd0, e_sum});
    chk({tag, "_carry"}, {31'd0, s_c}, {31'd0, e_c});
    chk({tag, "_ovf"}, {31'd0, s_o}, {31'd0, e_o});
    chk({tag, "_sum_hold"}, {24'd0, Sum}, {24'd0, e_sum});
  endtask

  initial begin
    int done_n;
    int last_done;
    int got;
    logic [8:0] ref_full;
    logic [7:0] ref_sum;
    logic       ref_ovf;
    logic [7:0] cur_a;
    logic [7:0] cur_b;
    logic       cur_ci;

    rst_n = 1'b0; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_done", {31'd0, Done}, 0);
    chk("rst_sum", {24'd0, Sum}, 0);
    chk("rst_carry", {31'd0, Carry}, 0);
    chk("rst_ovf", {31'd0, Ovf}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("basic", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

    // Async reset three cycles into RUN: all outputs clear without a clock edge.
    @(negedge clk);
    A = 8'hF0; B = 8'h0F; Cin = 1'b1; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun_busy", {31'd0, Busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, Busy}, 0);
    chk("arst_done", {31'd0, Done}, 0);
    chk("arst_sum", {24'd0, Sum}, 0);
    chk("arst_carry", {31'd0, Carry}, 0);
    chk("arst_ovf", {31'd0, Ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (Done || Busy) done_n++;
    end
    chk("post_rst_quiet", done_n, 0);

    run_op("wrap1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("wrap2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("ovf1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("ovf2", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Second Start while busy is dropped.
    @(negedge clk);
    A = 8'h12; B = 8'h34; Cin = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    A = 8'hAA; B = 8'h55; Cin = 1'b1; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    done_n = 0;
    got = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (Done) begin
        done_n++;
        got = {24'd0, Sum};
      end
    end
    chk("hs_done_cnt", done_n, 1);
    chk("hs_sum", got, 32'h46);
    chk("hs_hold", {24'd0, Sum}, 32'h46);
    chk("hs_idle", {31'd0, Busy}, 0);

    // Start held high: strided sweep of A and B with both carry-ins.
    last_done = -1;
    @(negedge clk);
    cur_a = 8'h00; cur_b = 8'h00; cur_ci = 1'b0;
    A = cur_a; B = cur_b; Cin = cur_ci; Start = 1'b1;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          cur_a  = 8'(ia * 17);
          cur_b  = 8'(ib * 17 + ia);
          cur_ci = ic[0];
          A = cur_a; B = cur_b; Cin = cur_ci;
          ref_full = {1'b0, cur_a} + {1'b0, cur_b} + {8'd0, cur_ci};
          ref_sum  = ref_full[7:0];
          ref_ovf  = (cur_a[7] == cur_b[7]) && (ref_sum[7] != cur_a[7]);
          got = 0;
          for (int w = 0; w < 14 && got == 0; w++) begin
            @(negedge clk);
            if (Done) got = 1;
          end
          chk("sweep_done_seen", got, 1);
          if (got == 0) begin
            $display("FAIL sweep_timeout: observed no Done, required Done within 14 cycles");
            $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
            $fatal(1, "sweep stalled");
          end
          chk("sweep_sum", {24'd0, Sum}, {24'd0, ref_sum});
          chk("sweep_carry", {31'd0, Carry}, {31'd0, ref_full[8]});
          chk("sweep_ovf", {31'd0, Ovf}, {31'd0, ref_ovf});
          if (last_done >= 0) chk("sweep_gap", cyc - last_done, 10);
          last_done = cyc;
        end
      end
    end
    Start = 1'b0;
    repeat (12) @(negedge clk);
    chk("end_idle", {31'd0, Busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
